// File: rtl/snn_ternary_layer.sv
// Time-multiplexed ternary-weight leaky integrate-and-fire layer: one neuron updated per cycle
// per accepted timestep, with a weight-write port and ready/valid step handshakes.
module snn_ternary_layer #(
  parameter int N_IN            = 4,
  parameter int N_OUT           = 4,
  parameter int POTENTIAL_WIDTH = 8,
  parameter int THRESHOLD       = 3,
  parameter int LEAK            = 0,
  parameter int REFRACTORY      = 0,
  parameter int REF_W           = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_valid,
  output logic                     step_ready,
  input  logic [N_IN-1:0]          spike_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT-1:0]         spike_out,
  input  logic                     wr_en,
  input  logic [$clog2(N_OUT)-1:0] wr_neuron,
  input  logic [$clog2(N_IN)-1:0]  wr_input,
  input  logic [1:0]               wr_weight,
  output logic                     wr_err,
  input  logic                     clear,
  output logic                     busy
);
  localparam int KW   = $clog2(N_OUT);
  localparam int PW   = POTENTIAL_WIDTH;
  localparam int SW   = POTENTIAL_WIDTH + $clog2(N_IN + 1) + 1;
  localparam int VMAX = 2 ** (PW - 1) - 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [N_IN-1:0]         in_q, in_d;
  logic [N_OUT-1:0]        spk_q, spk_d;
  logic                    wr_err_q, wr_err_d;
  logic [N_IN-1:0][1:0]    w_q [N_OUT];
  logic [N_IN-1:0][1:0]    w_d [N_OUT];
  logic signed [PW-1:0]    v_q [N_OUT];
  logic signed [PW-1:0]    v_d [N_OUT];
  logic [REF_W-1:0]        ref_q [N_OUT];
  logic [REF_W-1:0]        ref_d [N_OUT];

  logic signed [SW-1:0]    row_sum;
  logic signed [SW-1:0]    sum_next;
  logic signed [PW-1:0]    v_new;
  logic                    fire;
  logic                    wr_ok;

  // Datapath for the neuron currently selected by k_q; reserved code 10 counts as zero.
  always_comb begin
    row_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_q[i]) begin
        case (w_q[k_q][i])
          2'b01:   row_sum = row_sum + SW'(1);
          2'b11:   row_sum = row_sum - SW'(1);
          default: ;
        endcase
      end
    end
    sum_next = SW'(v_q[k_q]) + row_sum - SW'(LEAK);
    if (sum_next[SW-1]) begin
      v_new = '0;
    end else if (sum_next > SW'(VMAX)) begin
      v_new = PW'(VMAX);
    end else begin
      v_new = sum_next[PW-1:0];
    end
    fire = (v_new >= PW'(THRESHOLD));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    in_d    = in_q;
    spk_d   = spk_q;
    w_d     = w_q;
    v_d     = v_q;
    ref_d   = ref_q;

    wr_ok    = wr_en && (state_q == StIdle) && (32'(wr_neuron) < N_OUT) && (32'(wr_input) < N_IN);
    wr_err_d = wr_en && !wr_ok;
    if (wr_ok) begin
      w_d[wr_neuron][wr_input] = wr_weight;
    end

    unique case (state_q)
      StIdle: begin
        if (clear) begin
          v_d   = '{default: '0};
          ref_d = '{default: '0};
        end else if (step_valid) begin
          in_d    = spike_in;
          k_d     = '0;
          spk_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (ref_q[k_q] != '0) begin
          ref_d[k_q] = ref_q[k_q] - REF_W'(1);
          v_d[k_q]   = '0;
        end else if (fire) begin
          spk_d[k_q] = 1'b1;
          v_d[k_q]   = '0;
          ref_d[k_q] = REF_W'(REFRACTORY);
        end else begin
          v_d[k_q] = v_new;
        end
        if (k_q == KW'(N_OUT - 1)) begin
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      in_q     <= '0;
      spk_q    <= '0;
      wr_err_q <= 1'b0;
      w_q      <= '{default: '0};
      v_q      <= '{default: '0};
      ref_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      in_q     <= in_d;
      spk_q    <= spk_d;
      wr_err_q <= wr_err_d;
      w_q      <= w_d;
      v_q      <= v_d;
      ref_q    <= ref_d;
    end
  end

  assign step_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign spike_out  = spk_q;
  assign wr_err     = wr_err_q;

endmodule
